// File: rtl/leds_pkg.sv
// Shared encodings for the RGB/N-channel PWM sequencer: user modes and envelope FSM states.
package leds_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_STATIC    = 3'd1,
        S_BLINK_ON  = 3'd2,
        S_BLINK_OFF = 3'd3,
        S_RISE      = 3'd4,
        S_FALL      = 3'd5
    } state_e;

    // First envelope state entered when a mode is loaded.
    function automatic state_e entry_state(mode_e m);
        case (m)
            MODE_STATIC:  return S_STATIC;
            MODE_BLINK:   return S_BLINK_ON;
            MODE_BREATHE: return S_RISE;
            default:      return S_OFF;
        endcase
    endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_if.sv
// Control/LED bundle between board control logic (master) and the sequencer (slave).
interface rgb_pwm_sequencer_if #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
);
    logic [1:0]                   mode;
    logic [CHANNELS*PWM_BITS-1:0] level;
    logic                         load;
    logic [CHANNELS-1:0]          led;
    logic                         frame;

    modport master (output mode, output level, output load, input led, input frame);
    modport slave  (input mode, input level, input load, output led, output frame);
endinterface

// File: rtl/pwm_channel.sv
// One PWM output: holds its brightness level, scales it by the shared envelope and
// compares the frame-latched duty against the shared PWM counter.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                frame_i,
    input  logic [PWM_BITS-1:0] level_i,
    input  logic [PWM_BITS-1:0] env_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);
    localparam int PROD_W = 2 * PWM_BITS + 1;

    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic                led_q;
    logic [PROD_W-1:0]   level_ext;
    logic [PROD_W-1:0]   scale_ext;
    logic [PROD_W-1:0]   product;

    // env+1 makes a full-scale envelope return the level unchanged after the shift.
    assign level_ext = PROD_W'(level_q);
    assign scale_ext = PROD_W'(env_i) + PROD_W'(1);
    assign product   = level_ext * scale_ext;
    assign duty_d    = PWM_BITS'(product >> PWM_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            duty_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            // NOTE: duty only reloads on the frame pulse so a mid-frame load never
            // produces a truncated or stretched pulse on the pin.
            if (frame_i) duty_q <= duty_d;
            if (load_i)  level_q <= level_i;
            led_q <= (pwm_cnt_i < duty_q);
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// N-channel PWM LED driver: prescaler, frame counter and the shared off/static/blink/
// breathe envelope FSM; per-channel duty and output flops live in pwm_channel.
module rgb_pwm_sequencer
    import leds_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 12,
    parameter int BLINK_FRAMES = 32
) (
    input logic                clk,
    input logic                rst,
    rgb_pwm_sequencer_if.slave ctrl
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PWM_BITS-1:0] ENV_MAX    = '1;
    localparam logic [PWM_BITS-1:0] ENV_MAX_M1 = ENV_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] ENV_ONE    = PWM_BITS'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PRESCALE - 1);
    localparam logic [FC_W-1:0]     FC_LAST    = FC_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]    presc_q;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                frame_q;
    logic [FC_W-1:0]     fcnt_q;
    logic [PWM_BITS-1:0] env_q;
    state_e              state_q;
    mode_e               mode_q;
    mode_e               mode_in;
    logic [CHANNELS-1:0] led_w;

    assign tick    = (presc_q == PRE_LAST);
    assign mode_in = mode_e'(ctrl.mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            // NOTE: every state element updates with <= so all flops see the
            // pre-edge values of each other, independent of statement order.
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) pwm_cnt_q <= pwm_cnt_q + 1'b1;
            frame_q <= tick && (pwm_cnt_q == '1);
        end
    end

    // Load has priority over the frame advance, so a load landing on a frame
    // restarts the mode instead of also stepping the envelope.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_OFF;
            state_q <= S_OFF;
            env_q   <= '0;
            fcnt_q  <= '0;
        end else if (ctrl.load) begin
            mode_q  <= mode_in;
            state_q <= entry_state(mode_in);
            env_q   <= (mode_in == MODE_STATIC || mode_in == MODE_BLINK) ? ENV_MAX : '0;
            fcnt_q  <= '0;
        end else if (frame_q) begin
            unique case (state_q)
                S_OFF:    env_q <= '0;
                S_STATIC: env_q <= ENV_MAX;
                S_BLINK_ON: begin
                    if (fcnt_q == FC_LAST) begin
                        state_q <= S_BLINK_OFF;
                        env_q   <= '0;
                        fcnt_q  <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                S_BLINK_OFF: begin
                    if (fcnt_q == FC_LAST) begin
                        state_q <= S_BLINK_ON;
                        env_q   <= ENV_MAX;
                        fcnt_q  <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                S_RISE: begin
                    env_q <= env_q + 1'b1;
                    if (env_q == ENV_MAX_M1) state_q <= S_FALL;
                end
                S_FALL: begin
                    env_q <= env_q - 1'b1;
                    if (env_q == ENV_ONE) state_q <= S_RISE;
                end
                default: begin
                    state_q <= entry_state(mode_q);
                    env_q   <= '0;
                    fcnt_q  <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load_i    (ctrl.load),
            .frame_i   (frame_q),
            .level_i   (ctrl.level[i*PWM_BITS +: PWM_BITS]),
            .env_i     (env_q),
            .pwm_cnt_i (pwm_cnt_q),
            .led_o     (led_w[i])
        );
    end

    assign ctrl.led   = led_w;
    assign ctrl.frame = frame_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench: measures per-frame LED on-time and frame spacing against a
// mode/frame-index model of the envelope.
module tb_rgb_pwm_sequencer;
    import leds_pkg::*;

    localparam int CH    = 3;
    localparam int PB    = 4;
    localparam int PS    = 2;
    localparam int BF    = 2;
    localparam int FRAME = PS * (1 << PB);
    localparam int EMAX  = (1 << PB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb_pwm_sequencer_if #(.CHANNELS(CH), .PWM_BITS(PB)) ifc ();

    rgb_pwm_sequencer #(
        .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS), .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ifc)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: active mode, its levels and how many frames have used it since load.
    int mdl_md;
    int mdl_lvl[CH];
    int mdl_n;
    int nxt_md;
    int nxt_lvl[CH];
    bit synced;

    function automatic int env_of(input int md, input int n);
        int t;
        case (md)
            0: return 0;
            1: return EMAX;
            2: return (((n - 1) / BF) % 2 == 0) ? EMAX : 0;
            default: begin
                t = (n - 1) % (2 * EMAX);
                return (t <= EMAX) ? t : 2 * EMAX - t;
            end
        endcase
    endfunction

    function automatic int duty_of(input int md, input int lvl, input int n);
        return (lvl * (env_of(md, n) + 1)) >> PB;
    endfunction

    task automatic model_reset();
        mdl_md = 0;
        mdl_n  = 0;
        for (int c = 0; c < CH; c++) mdl_lvl[c] = 0;
        synced = 1'b0;
    endtask

    task automatic model_load();
        mdl_md = nxt_md;
        mdl_n  = 0;
        for (int c = 0; c < CH; c++) mdl_lvl[c] = nxt_lvl[c];
    endtask

    // Measures nwin frame windows; window k covers the LED cycles driven by the duty
    // latched at the k-th frame. Optional load pulse at offset load_at of window 0.
    task automatic measure(input string name, input int nwin, input bit do_load,
                           input int load_at);
        int hi[CH];
        int exp_hi[CH];
        bit frame_ok;
        int waited;
        if (!synced) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (ifc.frame !== 1'b1 && waited < 2 * FRAME);
            vectors++;
            if (ifc.frame !== 1'b1) begin
                errors++;
                $display("FAIL %s frame_sync: no frame within %0d clocks", name, 2 * FRAME);
            end
            @(negedge clk);
        end
        for (int k = 0; k < nwin; k++) begin
            if (do_load && k == 1 && load_at < FRAME - 2) model_load();
            mdl_n++;
            for (int c = 0; c < CH; c++) begin
                exp_hi[c] = PS * duty_of(mdl_md, mdl_lvl[c], mdl_n);
                hi[c] = 0;
            end
            if (do_load && k == 1 && load_at == FRAME - 2) model_load();
            frame_ok = 1'b1;
            for (int j = 0; j < FRAME; j++) begin
                @(negedge clk);
                for (int c = 0; c < CH; c++) hi[c] += int'(ifc.led[c]);
                if (ifc.frame !== (j == FRAME - 2)) frame_ok = 1'b0;
                ifc.load = (do_load && k == 0 && j == load_at);
                if (ifc.load) begin
                    ifc.mode = 2'(nxt_md);
                    for (int c = 0; c < CH; c++) ifc.level[c*PB +: PB] = PB'(nxt_lvl[c]);
                end
            end
            for (int c = 0; c < CH; c++) begin
                vectors++;
                if (hi[c] != exp_hi[c]) begin
                    errors++;
                    $display("FAIL %s win%0d led[%0d] on-clocks: got %0d expected %0d",
                             name, k, c, hi[c], exp_hi[c]);
                end
            end
            vectors++;
            if (!frame_ok) begin
                errors++;
                $display("FAIL %s win%0d frame: pulse not exactly at offset %0d", name, k, FRAME - 2);
            end
        end
        ifc.load = 1'b0;
        synced = 1'b1;
    endtask

    // After reset release with nothing loaded: LEDs dark, frames every FRAME clocks.
    task automatic idle_after_release(input string name);
        int frames[$];
        bit led_bad;
        led_bad = 1'b0;
        for (int i = 1; i <= 4 * FRAME + FRAME / 2; i++) begin
            @(negedge clk);
            if (ifc.led !== '0) led_bad = 1'b1;
            if (ifc.frame === 1'b1) frames.push_back(i);
        end
        vectors++;
        if (led_bad) begin
            errors++;
            $display("FAIL %s led_idle: led left 000 while idle", name);
        end
        vectors++;
        if (frames.size() != 4) begin
            errors++;
            $display("FAIL %s frame_count: got %0d pulses expected 4", name, frames.size());
        end else begin
            for (int f = 0; f < 4; f++) begin
                vectors++;
                if (frames[f] != (f + 1) * FRAME) begin
                    errors++;
                    $display("FAIL %s frame_pos%0d: got clock %0d expected %0d",
                             name, f, frames[f], (f + 1) * FRAME);
                end
            end
        end
        synced = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.load = 1'b0;
        ifc.mode = '0;
        ifc.level = '0;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (ifc.led !== '0 || ifc.frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: led=%b frame=%b expected 000/0", ifc.led, ifc.frame);
        end
        rst = 1'b0;
        idle_after_release("reset");
    endtask

    task automatic test_static();
        nxt_md = int'(MODE_STATIC);
        nxt_lvl[0] = 15; nxt_lvl[1] = 8; nxt_lvl[2] = 0;
        measure("static", 4, 1'b1, 5);
    endtask

    task automatic test_off_midframe();
        nxt_md = int'(MODE_OFF);
        for (int c = 0; c < CH; c++) nxt_lvl[c] = $urandom_range(0, EMAX);
        measure("off_midframe", 3, 1'b1, 10);
    endtask

    task automatic test_blink();
        nxt_md = int'(MODE_BLINK);
        for (int c = 0; c < CH; c++) nxt_lvl[c] = EMAX;
        measure("blink", 9, 1'b1, 12);
    endtask

    task automatic test_breathe();
        nxt_md = int'(MODE_BREATHE);
        nxt_lvl[0] = EMAX;
        nxt_lvl[1] = $urandom_range(0, EMAX);
        nxt_lvl[2] = $urandom_range(0, EMAX);
        measure("breathe", 2 * EMAX + 3, 1'b1, 20);
    endtask

    task automatic test_reload_same_mode();
        nxt_md = int'(MODE_BREATHE);
        for (int c = 0; c < CH; c++) nxt_lvl[c] = $urandom_range(EMAX / 2, EMAX);
        measure("reload_breathe", 6, 1'b1, 3);
    endtask

    task automatic test_load_on_frame();
        nxt_md = int'(MODE_STATIC);
        for (int c = 0; c < CH; c++) nxt_lvl[c] = $urandom_range(1, EMAX);
        measure("load_on_frame", 4, 1'b1, FRAME - 2);
    endtask

    task automatic test_random();
        int at;
        for (int it = 0; it < 8; it++) begin
            nxt_md = $urandom_range(0, 3);
            for (int c = 0; c < CH; c++) nxt_lvl[c] = $urandom_range(0, EMAX);
            at = ($urandom_range(0, 3) == 0) ? FRAME - 2 : $urandom_range(0, FRAME - 3);
            measure("random", 6, 1'b1, at);
        end
    endtask

    task automatic test_async_reset();
        int waited;
        nxt_md = int'(MODE_BREATHE);
        for (int c = 0; c < CH; c++) nxt_lvl[c] = EMAX;
        measure("pre_async", 4, 1'b1, 0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (ifc.led === '0 && waited < 4 * FRAME);
        vectors++;
        if (ifc.led === '0) begin
            errors++;
            $display("FAIL async_setup: led never lit within %0d clocks", 4 * FRAME);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ifc.led !== '0 || ifc.frame !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: led=%b frame=%b expected 000/0",
                     ifc.led, ifc.frame);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_after_release("async_reset");
        nxt_md = int'(MODE_STATIC);
        for (int c = 0; c < CH; c++) nxt_lvl[c] = $urandom_range(0, EMAX);
        measure("post_reset", 3, 1'b1, 7);
    endtask

    initial begin
        test_reset();
        test_static();
        test_off_midframe();
        test_blink();
        test_breathe();
        test_reload_same_mode();
        test_load_on_frame();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_sequencer.md
# rgb_pwm_sequencer

Parametrised multi-channel LED driver that generalises the fixed red/green/blue outputs into N PWM channels with a per-channel brightness setting. One shared envelope, running in off, static, blink or breathe mode, scales every channel. It sits between board-level control logic (buttons, UART command decoder) and the LED pins, and runs on the single board clock.

## Interface
- `CHANNELS`, 3: number of LED outputs; channel 0 = red, 1 = green, 2 = blue.
- `PWM_BITS`, 8: duty and envelope resolution; the PWM frame is 2^PWM_BITS ticks.
- `PRESCALE`, 12: clocks per PWM tick, ≥1.
- `BLINK_FRAMES`, 32: frames per blink half-period, ≥1.

- `clk`, in, 1: board clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `mode`, in, 2: 0 OFF, 1 STATIC, 2 BLINK, 3 BREATHE; sampled on `load`.
- `level`, in, CHANNELS*PWM_BITS: per-channel target brightness, channel 0 in the LSBs; sampled on `load`.
- `load`, in, 1: single-cycle strobe that captures `mode` and `level`.
- `led`, out, CHANNELS: registered PWM outputs, active-high.
- `frame`, out, 1: one-cycle pulse at each PWM frame boundary.

## Operation
**Prescaler**
- Counts 0..PRESCALE-1.
- `tick` is asserted when the count equals PRESCALE-1.
- With PRESCALE=1, `tick` is asserted every cycle.

**PWM counter**
- `pwm_cnt` is PWM_BITS wide and increments on each `tick`.
- It wraps from 2^PWM_BITS-1 to 0.
- `frame` pulses for one cycle on the tick that wraps the counter to 0.

**Duty computation and output**
- Duty is computed as `duty_next[i] = (level_reg[i] * (env+1)) >> PWM_BITS`.
  - The product is full width (2*PWM_BITS+1 bits) before the shift.
  - With env = max, duty equals level exactly.
- `duty[i]` loads `duty_next[i]` only in the `frame` cycle, which keeps the output glitch-free.
- `led[i]` is registered as `(pwm_cnt < duty[i])`.
  - Duty 0 gives a constant off.
  - Duty max gives on for (2^PWM_BITS-1) of 2^PWM_BITS ticks.

**Envelope FSM** (state, then envelope behaviour; FSM and frame counter advance only on `frame`)
- S_OFF: env = 0.
- S_STATIC: env = max.
- S_BLINK_ON: env = max. After BLINK_FRAMES frames go to S_BLINK_OFF, clearing the frame counter.
- S_BLINK_OFF: env = 0. After BLINK_FRAMES frames go to S_BLINK_ON.
- S_RISE: env += 1 per frame. On reaching max go to S_FALL.
- S_FALL: env -= 1 per frame. On reaching 0 go to S_RISE.
- Breathe period is 2*(2^PWM_BITS-1) frames; endpoint values are not repeated.

**Load behaviour**
- On `load`, `mode_reg` and `level_reg` capture the inputs.
- The FSM jumps to the entry state of the new mode:
  - OFF → S_OFF; STATIC → S_STATIC; BLINK → S_BLINK_ON; BREATHE → S_RISE.
  - Entering BREATHE also forces env = 0.
- The frame counter clears on every `load`.
- `load` repeated with the same mode restarts that mode.

**Boundary conditions**
- `load` in the same cycle as `frame`: the duty update uses the pre-load registers, and the load takes effect.
  - The FSM does not also advance in that cycle.
  - The new values reach `duty` at the next `frame`.
- `rst` mid-operation: every register returns to its reset value immediately; no partial frame completes.

## Timing
- Reset values:
  - `led` = 0, `frame` = 0.
  - prescaler, `pwm_cnt`, frame counter, env, `duty`, `level_reg` = 0.
  - `mode_reg` = OFF; FSM = S_OFF.
- `led` and `frame` are driven straight from flops; there is no combinational path from inputs to outputs.
- Frame period is PRESCALE * 2^PWM_BITS clocks.
- Latency from `load` to a `led` change is at most one frame period + 2 clocks.
- After reset release, the first `frame` occurs PRESCALE * 2^PWM_BITS clocks later.

## Structure
- Shared package `leds_pkg` holds:
  - the mode encodings MODE_OFF/STATIC/BLINK/BREATHE;
  - the FSM state encoding.
- Sub-module `pwm_channel`, instantiated CHANNELS times via generate, contains:
  - the level register;
  - the multiply-shift;
  - the frame-gated duty register;
  - the compare-output flop.
- The top level holds the prescaler, `pwm_cnt`, the frame counter, env and the FSM.

## Test plan
Bench parameters: CHANNELS=3, PWM_BITS=4, PRESCALE=2, BLINK_FRAMES=2; frame period is 32 clocks.
- Reset held, then released with no load → `led`=000 throughout. `frame` pulses every 32 clocks, first pulse 32 clocks after release.
- Load STATIC, levels {15,8,0} → from the second frame on:
  - `led[0]` high 30 of 32 clocks;
  - `led[1]` high 16 of 32 clocks;
  - `led[2]` constantly 0.
- Load BLINK, all levels 15 → `led`=111 duty-15 for 2 frames, then 000 for 2 frames, repeating.
- Load BREATHE, level[0]=15 → measured duty per frame: 0,1,…,15,14,…,1,0,1…, period 30 frames.
- Load OFF mid-frame while STATIC → old duty holds until the next `frame`, then `led`=000.
- `rst` asserted between clock edges during BREATHE:
  - `led` goes to 000 without a clock edge;
  - state matches the reset values after release.
